// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared tic-tac-toe state encodings, win-line masks and square helpers
package ttt_pkg;

    typedef enum logic [2:0] {
        ST_START = 3'd0,
        ST_PLAY  = 3'd1,
        ST_CHECK = 3'd2,
        ST_WIN_X = 3'd3,
        ST_WIN_O = 3'd4,
        ST_TIE   = 3'd5
    } state_t;

    localparam int SQ_IDX_W = 4;
    localparam int N_SQ     = 9;
    localparam logic [8:0] BOARD_FULL = 9'h1FF;

    // Rows, columns, then the two diagonals; bit i is square i in row-major order.
    localparam logic [8:0] WIN_LINES [8] = '{
        9'h007, 9'h038, 9'h1C0,
        9'h049, 9'h092, 9'h124,
        9'h111, 9'h054
    };

    function automatic logic is_onehot(input logic [8:0] v);
        return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
    endfunction

    function automatic logic [SQ_IDX_W-1:0] sq_index(input logic [8:0] v);
        logic [SQ_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_SQ; i++) begin
            if (v[i]) idx = SQ_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/win_checker.sv
// rtl/win_checker.sv - flags a completed line (row, column or diagonal) on one player's board
module win_checker
    import ttt_pkg::*;
(
    input  logic [8:0] board,
    output logic       win
);

    always_comb begin
        win = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if ((board & WIN_LINES[i]) == WIN_LINES[i]) win = 1'b1;
        end
    end

endmodule

// File: rtl/move_engine.sv
// rtl/move_engine.sv - tic-tac-toe move arbiter and game FSM; MOVE_ENGINE_UNDO_EN adds an undo LIFO
module move_engine
    import ttt_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = 1000000,
    parameter bit START_X        = 1'b1
)
(
    input  logic       CLK_100MHZ,
    input  logic       reset,
    input  logic [8:0] cuadro,
    input  logic       click,
    input  logic       erase,
    input  logic       restart,
    output logic [8:0] x,
    output logic [8:0] o,
    output logic       turnoX,
    output logic       inc_x_score,
    output logic       inc_o_score,
    output logic       reset_score,
    output logic       displayStartPlaying,
    output logic       displayGanadorX,
    output logic       displayGanadorO,
    output logic       displayEmpate,
    output logic       move_valid,
    output logic [2:0] state
);

    localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES - 1);

    state_t              state_q, state_d;
    logic                click_q, click_q2, click_evt;
    logic [HW-1:0]       holdoff_q;
    logic                win_x, win_o, board_full, sq_free;
    logic                accept, undo_act, clear_board;
    logic [SQ_IDX_W-1:0] pop_idx;

    assign click_evt  = click_q & ~click_q2;
    assign board_full = (x | o) == BOARD_FULL;
    assign sq_free    = (cuadro & (x | o)) == 9'd0;
    assign accept     = (state_q == ST_PLAY) && click_evt && !restart && !undo_act
                        && is_onehot(cuadro) && sq_free && (holdoff_q == '0);
    assign state      = state_q;

    win_checker u_win_x (.board(x), .win(win_x));
    win_checker u_win_o (.board(o), .win(win_o));

`ifdef MOVE_ENGINE_UNDO_EN
    logic [SQ_IDX_W-1:0] lifo [N_SQ];
    logic [3:0]          sp;

    assign undo_act = (state_q == ST_PLAY) && erase && !restart && (sp != 4'd0);
    assign pop_idx  = (sp == 4'd0) ? '0 : lifo[sp - 4'd1];

    always_ff @(posedge CLK_100MHZ) begin
        if (!reset) begin
            sp <= 4'd0;
        end else if (clear_board) begin
            sp <= 4'd0;
        end else if (accept) begin
            lifo[sp] <= sq_index(cuadro);
            sp       <= sp + 4'd1;
        end else if (undo_act) begin
            sp <= sp - 4'd1;
        end
    end
`else
    logic unused_erase;
    assign unused_erase = erase;
    assign undo_act     = 1'b0;
    assign pop_idx      = '0;
`endif

    always_ff @(posedge CLK_100MHZ) begin
        if (!reset) state_q <= ST_START;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_START: if (click_evt) state_d = ST_PLAY;
            ST_PLAY: begin
                if (restart)     state_d = ST_PLAY;
                else if (accept) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (restart)         state_d = ST_PLAY;
                else if (win_x)      state_d = ST_WIN_X;
                else if (win_o)      state_d = ST_WIN_O;
                else if (board_full) state_d = ST_TIE;
                else                 state_d = ST_PLAY;
            end
            ST_WIN_X, ST_WIN_O, ST_TIE: if (click_evt || restart) state_d = ST_PLAY;
            default: state_d = ST_START;
        endcase
    end

    always_comb begin
        displayStartPlaying = (state_q == ST_START);
        displayGanadorX     = (state_q == ST_WIN_X);
        displayGanadorO     = (state_q == ST_WIN_O);
        displayEmpate       = (state_q == ST_TIE);
        clear_board         = 1'b0;
        case (state_q)
            ST_START:                   clear_board = click_evt;
            ST_PLAY, ST_CHECK:          clear_board = restart;
            ST_WIN_X, ST_WIN_O, ST_TIE: clear_board = click_evt | restart;
            default:                    clear_board = 1'b0;
        endcase
    end

    // Score pulses are gated on restart so an abandoned CHECK never scores.
    always_ff @(posedge CLK_100MHZ) begin
        if (!reset) begin
            click_q     <= 1'b0;
            click_q2    <= 1'b0;
            holdoff_q   <= '0;
            x           <= 9'd0;
            o           <= 9'd0;
            turnoX      <= START_X;
            move_valid  <= 1'b0;
            reset_score <= 1'b0;
            inc_x_score <= 1'b0;
            inc_o_score <= 1'b0;
        end else begin
            click_q     <= click;
            click_q2    <= click_q;
            move_valid  <= accept;
            reset_score <= (state_q == ST_START) && click_evt;
            inc_x_score <= (state_q == ST_CHECK) && !restart && win_x;
            inc_o_score <= (state_q == ST_CHECK) && !restart && !win_x && win_o;

            if (accept)                holdoff_q <= HOLD_LOAD;
            else if (holdoff_q != '0)  holdoff_q <= holdoff_q - 1'b1;

            if (clear_board) begin
                x      <= 9'd0;
                o      <= 9'd0;
                turnoX <= START_X;
            end else if (accept) begin
                if (turnoX) x <= x | cuadro;
                else        o <= o | cuadro;
                turnoX <= ~turnoX;
            end else if (undo_act) begin
                x      <= x & ~(9'd1 << pop_idx);
                o      <= o & ~(9'd1 << pop_idx);
                turnoX <= ~turnoX;
            end
        end
    end

endmodule

// File: tb/tb_move_engine.sv
// tb/tb_move_engine.sv - directed self-checking bench for move_engine
module tb_move_engine;

    logic       CLK_100MHZ = 1'b0;
    logic       reset, click, erase, restart;
    logic [8:0] cuadro;
    logic [8:0] x, o;
    logic       turnoX, inc_x_score, inc_o_score, reset_score, move_valid;
    logic       displayStartPlaying, displayGanadorX, displayGanadorO, displayEmpate;
    logic [2:0] state;

    int n_vec = 0;
    int n_err = 0;
    int mv_cnt = 0, rs_cnt = 0, ix_cnt = 0, io_cnt = 0;
    int mv0, rs0, ix0, io0;

    move_engine #(.HOLDOFF_CYCLES(4), .START_X(1'b1)) dut (
        .CLK_100MHZ(CLK_100MHZ), .reset(reset), .cuadro(cuadro), .click(click),
        .erase(erase), .restart(restart), .x(x), .o(o), .turnoX(turnoX),
        .inc_x_score(inc_x_score), .inc_o_score(inc_o_score), .reset_score(reset_score),
        .displayStartPlaying(displayStartPlaying), .displayGanadorX(displayGanadorX),
        .displayGanadorO(displayGanadorO), .displayEmpate(displayEmpate),
        .move_valid(move_valid), .state(state)
    );

    always #5 CLK_100MHZ = ~CLK_100MHZ;

    always @(negedge CLK_100MHZ) begin
        if (move_valid)  mv_cnt++;
        if (reset_score) rs_cnt++;
        if (inc_x_score) ix_cnt++;
        if (inc_o_score) io_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_100MHZ);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Returns just after the accepting edge with click released.
    task automatic move(input int sq);
        cuadro = 9'd1 << sq;
        click  = 1'b1;
        tick();
        tick();
        check($sformatf("move_valid_sq%0d", sq), move_valid, 1);
        click = 1'b0;
    endtask

    task automatic try_click(input logic [8:0] v);
        cuadro = v;
        click  = 1'b1;
        tick();
        tick();
        click = 1'b0;
        tick();
        tick();
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    initial begin
        int tie_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

        reset = 1'b0; cuadro = 9'd0; click = 1'b0; erase = 1'b0; restart = 1'b0;
        tick(); tick();
        check("rst_state", state, 0);
        check("rst_x", x, 0);
        check("rst_o", o, 0);
        check("rst_turn", turnoX, 1);
        check("rst_disp", {displayStartPlaying, displayGanadorX, displayGanadorO, displayEmpate}, 4'b1000);
        check("rst_pulses", {move_valid, reset_score, inc_x_score, inc_o_score}, 0);
        reset = 1'b1;
        tick();

        // Held click in START: exactly one reset_score pulse.
        click = 1'b1;
        idle(5);
        click = 1'b0;
        idle(2);
        check("start_rs_cnt", rs_cnt, 1);
        check("start_state", state, 1);
        check("start_turn", turnoX, 1);
        check("start_board", {x, o}, 0);
        check("start_disp", {displayStartPlaying, displayGanadorX, displayGanadorO, displayEmpate}, 0);

        mv0 = mv_cnt;
        try_click(9'h003);
        check("twohot_mv", mv_cnt - mv0, 0);
        check("twohot_board", {x, o}, 0);
        check("twohot_turn", turnoX, 1);

        // X wins on the 0/4/8 diagonal.
        move(0); tick();
        check("x0_state", state, 1);
        check("x0_x", x, 9'h001);
        check("x0_turn", turnoX, 0);
        idle(3);
        mv0 = mv_cnt;
        try_click(9'h001);
        check("occupied_mv", mv_cnt - mv0, 0);
        check("occupied_o", o, 0);
        check("occupied_turn", turnoX, 0);
        move(3); tick(); idle(3);
        move(4); tick(); idle(3);
        move(5); tick(); idle(3);
        move(8);
        check("win_check_state", state, 2);
        tick();
        check("win_state", state, 3);
        check("win_inc_x", inc_x_score, 1);
        tick();
        check("win_inc_x_done", inc_x_score, 0);
        check("win_disp", {displayStartPlaying, displayGanadorX, displayGanadorO, displayEmpate}, 4'b0100);
        check("win_x", x, 9'h111);
        check("win_o", o, 9'h028);
        check("win_ix_cnt", ix_cnt, 1);
        check("win_io_cnt", io_cnt, 0);

        rs0 = rs_cnt;
        pulse_restart();
        check("rs_win_state", state, 1);
        check("rs_win_board", {x, o}, 0);
        check("rs_win_turn", turnoX, 1);
        tick();
        check("rs_win_scores", rs_cnt - rs0, 0);

        // Second click edge inside holdoff window is dropped.
        mv0 = mv_cnt;
        cuadro = 9'h001; click = 1'b1;
        tick(); tick();
        click = 1'b0;
        tick();
        cuadro = 9'h002; click = 1'b1;
        tick(); tick();
        check("holdoff_mv_now", move_valid, 0);
        check("holdoff_mv_cnt", mv_cnt - mv0, 1);
        check("holdoff_o", o, 0);
        check("holdoff_turn", turnoX, 0);
        click = 1'b0;
        idle(4);

        pulse_restart();
        idle(4);
        ix0 = ix_cnt; io0 = io_cnt;
        foreach (tie_seq[i]) begin
            move(tie_seq[i]); tick(); idle(3);
        end
        check("tie_state", state, 5);
        check("tie_disp", {displayStartPlaying, displayGanadorX, displayGanadorO, displayEmpate}, 4'b0001);
        check("tie_full", x | o, 9'h1FF);
        check("tie_x", x, 9'h18D);
        check("tie_scores", (ix_cnt - ix0) + (io_cnt - io0), 0);

        pulse_restart();
        idle(4);
`ifdef MOVE_ENGINE_UNDO_EN
        move(0); tick(); idle(3);
        move(4); tick(); idle(1);
        erase = 1'b1; tick(); erase = 1'b0;
        check("undo_o", o, 0);
        check("undo_x", x, 9'h001);
        check("undo_turn", turnoX, 0);
        erase = 1'b1; restart = 1'b1; tick();
        erase = 1'b0; restart = 1'b0;
        check("undo_rs_board", {x, o}, 0);
        check("undo_rs_turn", turnoX, 1);
        check("undo_rs_state", state, 1);
`else
        move(0); tick(); idle(1);
        erase = 1'b1; tick(); erase = 1'b0;
        check("erase_ign_x", x, 9'h001);
        check("erase_ign_turn", turnoX, 0);
        pulse_restart();
`endif
        idle(4);

        // Reset while CHECK holds a winning board: no score pulse.
        ix0 = ix_cnt;
        move(0); tick(); idle(3);
        move(3); tick(); idle(3);
        move(1); tick(); idle(3);
        move(4); tick(); idle(3);
        move(2);
        check("abort_check_state", state, 2);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_state", state, 0);
        check("abort_board", {x, o}, 0);
        tick();
        check("abort_ix_cnt", ix_cnt - ix0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
